// File: rtl/image_load_ctrl.sv
// Avalon-MM sequencer that stages pixel words in a small FIFO and streams one
// image into the classifier, then latches its result and raises an interrupt.
module image_load_ctrl #(
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_IMAGE = 196,
  parameter int FIFO_DEPTH      = 8,
  parameter int RESULT_W        = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic                read_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq,
  output logic [DATA_W-1:0]   px_data,
  output logic                px_valid,
  input  logic                px_ready,
  output logic                px_last,
  output logic                cls_start,
  input  logic                cls_done,
  input  logic [RESULT_W-1:0] cls_result
);

  // state     | meaning
  // IDLE      | waiting for START; FIFO may be loaded
  // STREAM    | sending FIFO words to the classifier
  // WAIT_DONE | all words sent, waiting for cls_done
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [15:0]   LAST_IDX = 16'(WORDS_PER_IMAGE - 1);

  logic [1:0]          state;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  logic [15:0]         count;
  logic                done, ovf, irq_en, cls_start_q;
  logic [RESULT_W-1:0] result;

  logic wr_en, rd_en, data_wr, ctrl_wr, stat_wr;
  logic start_req, abort_req, empty, full, busy, pop, push, last_xfer, done_evt;

  assign wr_en   = chipselect & ~write_n;
  assign rd_en   = chipselect & ~read_n;
  assign data_wr = wr_en & (address == 2'd0);
  assign ctrl_wr = wr_en & (address == 2'd1);
  assign stat_wr = wr_en & (address == 2'd2);

  // ABORT wins over START written in the same word
  assign abort_req = ctrl_wr & writedata[1];
  assign start_req = ctrl_wr & writedata[0] & ~writedata[1] & (state == ST_IDLE);

  assign empty     = (level == '0);
  assign full      = (level == DEPTH_L);
  assign busy      = (state != ST_IDLE);
  assign px_valid  = (state == ST_STREAM) & ~empty;
  assign pop       = px_valid & px_ready;
  assign push      = data_wr & (~full | pop);
  assign last_xfer = pop & (count == LAST_IDX);
  assign done_evt  = cls_done & (state == ST_WAIT);

  assign px_data   = px_valid ? mem[rd_ptr] : '0;
  assign px_last   = px_valid & (count == LAST_IDX);
  assign cls_start = cls_start_q;
  assign irq       = done & irq_en;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (abort_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      count       <= '0;
      cls_start_q <= 1'b0;
    end else begin
      cls_start_q <= start_req;
      if (abort_req) begin
        state <= ST_IDLE;
        count <= '0;
      end else begin
        if (start_req)  count <= '0;
        else if (pop)   count <= count + 16'd1;
        case (state)
          ST_IDLE:   if (start_req) state <= ST_STREAM;
          ST_STREAM: if (last_xfer) state <= ST_WAIT;
          ST_WAIT:   if (cls_done)  state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      ovf    <= 1'b0;
      irq_en <= 1'b0;
      result <= '0;
    end else begin
      if (ctrl_wr) irq_en <= writedata[2];
      if (done_evt) result <= cls_result;
      if (done_evt)                        done <= 1'b1;
      else if (start_req)                  done <= 1'b0;
      else if (stat_wr && writedata[1])    done <= 1'b0;
      if (data_wr && full && !pop)         ovf <= 1'b1;
      else if (stat_wr && writedata[2])    ovf <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    if (rd_en) begin
      case (address)
        2'd1:    readdata = {29'b0, irq_en, 2'b00};
        2'd2:    readdata = {count, 8'(level), 3'b000, full, empty, ovf, done, busy};
        2'd3:    readdata = 32'(result);
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_image_load_ctrl.sv
// Directed bench for image_load_ctrl with WORDS_PER_IMAGE=4, FIFO_DEPTH=8.
module tb_image_load_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] px_data;
  logic        px_valid;
  logic        px_ready = 1'b0;
  logic        px_last;
  logic        cls_start;
  logic        cls_done = 1'b0;
  logic [3:0]  cls_result = '0;

  int tests = 0;
  int fails = 0;
  logic [31:0] got [4];
  logic        lastf [4];
  int          ngot;
  logic [31:0] rv;

  image_load_ctrl #(.DATA_W(32), .WORDS_PER_IMAGE(4), .FIFO_DEPTH(8), .RESULT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_last(px_last), .cls_start(cls_start), .cls_done(cls_done), .cls_result(cls_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1 d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic pulse_done(input logic [3:0] r);
    @(negedge clk);
    cls_done = 1'b1; cls_result = r;
    @(negedge clk);
    cls_done = 1'b0; cls_result = '0;
  endtask

  // Collect up to 4 transfers; optional ready toggling with two refill writes.
  task automatic collect(input bit toggle, input logic [31:0] wa, input logic [31:0] wb);
    ngot = 0;
    for (int i = 0; i < 60 && ngot < 4; i++) begin
      if (toggle) begin
        px_ready = i[0];
        if (i == 3 || i == 6) begin
          address = 2'd0; writedata = (i == 3) ? wa : wb;
          chipselect = 1'b1; write_n = 1'b0;
        end else begin
          chipselect = 1'b0; write_n = 1'b1;
        end
      end
      #1;
      if (px_valid && px_ready) begin
        got[ngot] = px_data; lastf[ngot] = px_last; ngot++;
      end
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;
    chk("xfer_count", 32'(ngot), 32'd4);
  endtask

  task automatic chk_words(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    chk({tag, "_w0"}, got[0], w0);
    chk({tag, "_w1"}, got[1], w1);
    chk({tag, "_w2"}, got[2], w2);
    chk({tag, "_w3"}, got[3], w3);
    chk({tag, "_last"}, {28'b0, lastf[3], lastf[2], lastf[1], lastf[0]}, 32'h8);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_px_valid", 32'(px_valid), 32'd0);
    chk("rst_px_data", px_data, 32'd0);
    chk("rst_cls_start", 32'(cls_start), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    rd(2'd2, rv); chk("rst_status", rv, 32'h0000_0008);
    rd(2'd3, rv); chk("rst_result", rv, 32'd0);

    // basic image
    wr(2'd1, 32'h4);
    rd(2'd1, rv); chk("ctrl_irq_en", rv, 32'h4);
    wr(2'd0, 32'h11); wr(2'd0, 32'h22); wr(2'd0, 32'h33); wr(2'd0, 32'h44);
    rd(2'd2, rv); chk("t1_status_loaded", rv, 32'h0000_0400);
    wr(2'd1, 32'h5);
    #1;
    chk("t1_cls_start_hi", 32'(cls_start), 32'd1);
    chk("t1_head", px_data, 32'h11);
    chk("t1_px_valid", 32'(px_valid), 32'd1);
    @(negedge clk); #1;
    chk("t1_cls_start_lo", 32'(cls_start), 32'd0);
    px_ready = 1'b1;
    collect(1'b0, '0, '0);
    chk_words("t1", 32'h11, 32'h22, 32'h33, 32'h44);
    chk("t1_wait_valid", 32'(px_valid), 32'd0);
    rd(2'd2, rv); chk("t1_status_wait", rv, 32'h0004_0009);
    pulse_done(4'd7);
    rd(2'd2, rv); chk("t1_status_done", rv, 32'h0004_000A);
    rd(2'd3, rv); chk("t1_result", rv, 32'd7);
    #1 chk("t1_irq", 32'(irq), 32'd1);
    wr(2'd1, 32'h0);
    #1 chk("t1_irq_masked", 32'(irq), 32'd0);
    wr(2'd1, 32'h4);
    wr(2'd2, 32'h2);
    #1 chk("t1_irq_cleared", 32'(irq), 32'd0);

    // overflow
    px_ready = 1'b0;
    for (int k = 0; k < 9; k++) wr(2'd0, 32'hA0 + 32'(k));
    rd(2'd2, rv); chk("t2_status_ovf", rv, 32'h0004_0814);
    wr(2'd2, 32'h4);
    rd(2'd2, rv); chk("t2_ovf_clear", rv, 32'h0004_0810);

    // second START and early cls_done ignored
    wr(2'd1, 32'h5);
    #1 chk("t5_cls_start", 32'(cls_start), 32'd1);
    wr(2'd1, 32'h5);
    #1 chk("t5_restart_ignored", 32'(cls_start), 32'd0);
    pulse_done(4'd3);
    rd(2'd2, rv); chk("t5_status_stream", rv, 32'h0000_0811);
    rd(2'd3, rv); chk("t5_result_kept", rv, 32'd7);
    px_ready = 1'b1;
    collect(1'b0, '0, '0);
    chk_words("t5", 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    rd(2'd2, rv); chk("t5_status_wait", rv, 32'h0004_0401);
    pulse_done(4'd9);
    rd(2'd2, rv); chk("t5_status_done", rv, 32'h0004_0402);
    rd(2'd3, rv); chk("t5_result", rv, 32'd9);
    wr(2'd1, 32'h5);
    collect(1'b0, '0, '0);
    chk_words("t2_drain", 32'hA4, 32'hA5, 32'hA6, 32'hA7);
    rd(2'd2, rv); chk("t2_drained", rv, 32'h0004_0009);
    pulse_done(4'd2);
    rd(2'd3, rv); chk("t2_result", rv, 32'd2);

    // toggling ready with refill during STREAM
    px_ready = 1'b0;
    wr(2'd0, 32'hC0); wr(2'd0, 32'hC1);
    wr(2'd1, 32'h5);
    collect(1'b1, 32'hC2, 32'hC3);
    chk_words("t3", 32'hC0, 32'hC1, 32'hC2, 32'hC3);
    px_ready = 1'b0;
    rd(2'd2, rv); chk("t3_status_wait", rv, 32'h0004_0009);
    pulse_done(4'd5);
    rd(2'd3, rv); chk("t3_result", rv, 32'd5);

    // abort mid-image (START bit set too: abort wins)
    wr(2'd0, 32'hD0); wr(2'd0, 32'hD1); wr(2'd0, 32'hD2); wr(2'd0, 32'hD3);
    wr(2'd1, 32'h5);
    px_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    px_ready = 1'b0;
    rd(2'd2, rv); chk("t4_status_mid", rv, 32'h0002_0201);
    wr(2'd1, 32'h7);
    #1 chk("t4_no_start", 32'(cls_start), 32'd0);
    rd(2'd2, rv); chk("t4_status_abort", rv, 32'h0000_0008);
    pulse_done(4'hF);
    rd(2'd2, rv); chk("t4_done_ignored", rv, 32'h0000_0008);
    rd(2'd3, rv); chk("t4_result_kept", rv, 32'd5);

    // async reset during STREAM
    wr(2'd0, 32'hE0); wr(2'd0, 32'hE1);
    wr(2'd1, 32'h5);
    #1 chk("t6_valid_pre", 32'(px_valid), 32'd1);
    chk("t6_head_pre", px_data, 32'hE0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_px_valid", 32'(px_valid), 32'd0);
    chk("t6_px_data", px_data, 32'd0);
    chk("t6_px_last", 32'(px_last), 32'd0);
    chk("t6_cls_start", 32'(cls_start), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    rd(2'd2, rv); chk("t6_status", rv, 32'h0000_0008);
    rd(2'd1, rv); chk("t6_ctrl", rv, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
